// File: rtl/clock_counter_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_counter_reader_pkg
// Purpose  : Shared types and constants for the clock counter reader.
//            FSM state encoding, default count width, frame length and
//            half-period timer width.
// Config   : none (CLOCK_COUNTER_READER_DELTA_EN is consumed by the top)
// Revision : 1.0 - initial release
// ============================================================================
package clock_counter_reader_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_L  = 3'd1,
    LOAD_H  = 3'd2,
    SHIFT_L = 3'd3,
    SHIFT_H = 3'd4,
    DONE    = 3'd5
  } ccr_state_e;

  // Default CPLD count width and the resulting frame (flag + count)
  localparam int CCR_COUNTER_BITS = 27;
  localparam int CCR_FRAME_BITS   = CCR_COUNTER_BITS + 1;

  // Half-period timer width: covers SCLK_HALF up to 255
  localparam int CCR_HALF_W = 8;

  function automatic int ccr_frame_bits(input int counter_bits);
    return counter_bits + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_counter_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_counter_reader_if
// Purpose  : Host request/result signals plus the SPI link to the CPLD.
//   master : reader side  - in: start, spi_miso
//                           out: busy, rd_valid, rd_flag, rd_count, rd_delta,
//                                rd_delta_valid, spi_clk, spi_sen, spi_mosi
//   slave  : host + CPLD side (directions mirrored)
// Revision : 1.0 - initial release
// ============================================================================
interface clock_counter_reader_if
  import clock_counter_reader_pkg::*;
#(
  parameter int COUNTER_BITS = CCR_COUNTER_BITS
);
  logic                    start;
  logic                    busy;
  logic                    rd_valid;
  logic                    rd_flag;
  logic [COUNTER_BITS-1:0] rd_count;
  logic [COUNTER_BITS-1:0] rd_delta;
  logic                    rd_delta_valid;
  logic                    spi_clk;
  logic                    spi_sen;
  logic                    spi_miso;
  logic                    spi_mosi;

  modport master (
    input  start, spi_miso,
    output busy, rd_valid, rd_flag, rd_count, rd_delta, rd_delta_valid,
           spi_clk, spi_sen, spi_mosi
  );

  modport slave (
    output start, spi_miso,
    input  busy, rd_valid, rd_flag, rd_count, rd_delta, rd_delta_valid,
           spi_clk, spi_sen, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/ccr_half_timer.sv
`default_nettype none
// ============================================================================
// Module   : ccr_half_timer
// Purpose  : Loadable down-counter timing one spi_clk half-period.
//            'last' is high on the final cycle of each SCLK_HALF-cycle phase.
// Ports    : clk, nreset (async, active-low)
//            load - reload to SCLK_HALF-1 (phase start)
//            last - final cycle of the current phase
// Revision : 1.0 - initial release
// ============================================================================
module ccr_half_timer
  import clock_counter_reader_pkg::*;
#(
  parameter int SCLK_HALF = 4
)(
  input  logic clk,
  input  logic nreset,
  input  logic load,
  output logic last
);
  localparam logic [CCR_HALF_W-1:0] RELOAD = CCR_HALF_W'(SCLK_HALF - 1);

  logic [CCR_HALF_W-1:0] count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CCR_HALF_W'(1);
    end
  end

  assign last = (count == '0);

endmodule
`default_nettype wire

// File: rtl/clock_counter_reader.sv
`default_nettype none
// ============================================================================
// Module   : clock_counter_reader
// Purpose  : SPI master reading the PPS-latched {flag, count} word out of
//            the CPLD clock counter: one load edge (sen low) followed by
//            COUNTER_BITS shift edges (sen high), MSB first.
// Ports    : clk, nreset (async, active-low)
//            bus (clock_counter_reader_if.master): start/busy handshake,
//            rd_valid strobe with rd_flag/rd_count/rd_delta/rd_delta_valid,
//            SPI spi_clk/spi_sen/spi_mosi out, spi_miso in.
// Config   : CLOCK_COUNTER_READER_DELTA_EN - when defined, tracks the last
//            capture and reports the wrap-safe delta between captures.
//            Otherwise rd_delta/rd_delta_valid are held at zero.
// Revision : 1.0 - initial release
// ============================================================================
module clock_counter_reader
  import clock_counter_reader_pkg::*;
#(
  parameter int COUNTER_BITS = CCR_COUNTER_BITS,
  parameter int SCLK_HALF    = 4
)(
  input  logic                   clk,
  input  logic                   nreset,
  clock_counter_reader_if.master bus
);
  localparam int FRAME_BITS = ccr_frame_bits(COUNTER_BITS);
  localparam int BCNT_W     = $clog2(COUNTER_BITS + 1);

  ccr_state_e              state;
  ccr_state_e              state_nxt;
  logic [COUNTER_BITS-1:0] shreg;
  logic [BCNT_W-1:0]       bitcnt;
  logic                    half_last;
  logic                    half_load;
  logic                    frame_end;
  logic [FRAME_BITS-1:0]   word_in;

  logic                    spi_clk_q;
  logic                    spi_sen_q;
  logic                    rd_valid_q;
  logic                    rd_flag_q;
  logic [COUNTER_BITS-1:0] rd_count_q;

  // Every phase restarts the timer; IDLE/DONE keep it primed so the
  // first LOAD_L phase runs a full SCLK_HALF cycles.
  assign half_load = (state == IDLE) || (state == DONE) || half_last;

  ccr_half_timer #(
    .SCLK_HALF (SCLK_HALF)
  ) u_half_timer (
    .clk    (clk),
    .nreset (nreset),
    .load   (half_load),
    .last   (half_last)
  );

  // Only the first COUNTER_BITS bits are held in shreg; the final bit is
  // merged here and goes straight into the result registers, so results
  // are already valid in the DONE cycle.
  assign word_in   = {shreg, bus.spi_miso};
  assign frame_end = (state == SHIFT_L) && half_last && (bitcnt == '0);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD_L;
      LOAD_L:  if (half_last) state_nxt = LOAD_H;
      LOAD_H:  if (half_last) state_nxt = SHIFT_L;
      SHIFT_L: if (half_last) state_nxt = (bitcnt == '0) ? DONE : SHIFT_H;
      SHIFT_H: if (half_last) state_nxt = SHIFT_L;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered SPI outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bitcnt     <= '0;
      shreg      <= '0;
      spi_clk_q  <= 1'b0;
      spi_sen_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_flag_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      // SPI lines decoded from the next state so they are flop outputs
      // aligned with the state register.
      spi_clk_q  <= (state_nxt == LOAD_H)  || (state_nxt == SHIFT_H);
      spi_sen_q  <= (state_nxt == SHIFT_L) || (state_nxt == SHIFT_H);
      rd_valid_q <= frame_end;

      if ((state == IDLE) && bus.start) begin
        bitcnt <= BCNT_W'(COUNTER_BITS);
      end else if ((state == SHIFT_H) && half_last) begin
        bitcnt <= bitcnt - BCNT_W'(1);
      end

      // Sample one cycle before spi_clk rises, giving the CPLD
      // SCLK_HALF-1 cycles of settling after the falling edge.
      if ((state == SHIFT_L) && half_last) begin
        shreg <= word_in[COUNTER_BITS-1:0];
      end

      if (frame_end) begin
        rd_flag_q  <= word_in[COUNTER_BITS];
        rd_count_q <= word_in[COUNTER_BITS-1:0];
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_flag  = rd_flag_q;
  assign bus.rd_count = rd_count_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.spi_sen  = spi_sen_q;
  assign bus.spi_mosi = 1'b0;

  // --------------------------------------------------------------------------
  // Optional capture-to-capture delta
  // --------------------------------------------------------------------------
`ifdef CLOCK_COUNTER_READER_DELTA_EN
  logic [COUNTER_BITS-1:0] prev_count;
  logic                    prev_ok;
  logic [COUNTER_BITS-1:0] delta_q;
  logic                    delta_valid_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev_count    <= '0;
      prev_ok       <= 1'b0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
    end else if (frame_end) begin
      delta_valid_q <= 1'b0;
      // Flag clear means the CPLD has no capture yet; a repeated count
      // means no new PPS since the previous read. Neither updates state.
      if (word_in[COUNTER_BITS]) begin
        if (!prev_ok) begin
          prev_count <= word_in[COUNTER_BITS-1:0];
          prev_ok    <= 1'b1;
        end else if (word_in[COUNTER_BITS-1:0] != prev_count) begin
          // Modular subtraction handles counter wrap between captures
          delta_q       <= word_in[COUNTER_BITS-1:0] - prev_count;
          delta_valid_q <= 1'b1;
          prev_count    <= word_in[COUNTER_BITS-1:0];
        end
      end
    end
  end

  assign bus.rd_delta       = delta_q;
  assign bus.rd_delta_valid = delta_valid_q;
`else
  assign bus.rd_delta       = '0;
  assign bus.rd_delta_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/clock_counter_reader.md
# clock_counter_reader

Host-side SPI master that reads the 1PPS-latched clock count out of the CPLD clock counter. On request it drives `spi_sen`/`spi_clk` through one load-and-shift frame, collects the {flag, count} word MSB-first and presents it on a valid strobe. Optionally it also computes the wrap-safe count delta between successive PPS captures, giving clock cycles per PPS interval for GPS disciplining. It sits in the MCU-side FPGA/CPLD glue, clocked from the local system clock.

## Interface
- `COUNTER_BITS`, 27: count width; the frame is `COUNTER_BITS+1` bits (flag + count).
- `SCLK_HALF`, 4: `clk` cycles per `spi_clk` half-period; legal range 2..255.
- `clk` in 1: system clock; all logic on its rising edge.
- `nreset` in 1: reset, asynchronous, active-low.
- `start` in 1: read request; sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until `rd_valid`, inclusive.
- `rd_valid` out 1: one-cycle strobe; result outputs are updated in this cycle.
- `rd_flag` out 1: received MSB; 1 means at least one PPS has been captured since the CPLD reset.
- `rd_count` out `COUNTER_BITS`: received count.
- `rd_delta` out `COUNTER_BITS`: cycles between the last two distinct captures.
- `rd_delta_valid` out 1: qualifies `rd_delta`; meaningful only while `rd_valid` is high.
- `spi_clk` out 1: serial clock to the CPLD; idles low.
- `spi_sen` out 1: serial enable. Low = load, high = shift.
- `spi_miso` in 1: CPLD serial data out.
- `spi_mosi` out 1: tied to 0.

## Operation
- FSM states: IDLE, LOAD_L, LOAD_H, SHIFT_L, SHIFT_H, DONE.
- IDLE: `sen`=0, `sclk`=0. On `start`=1, go to LOAD_L and clear the bit counter to `COUNTER_BITS`.
- LOAD_L: `sen`=0, `sclk`=0 for `SCLK_HALF` cycles, then go to LOAD_H.
- LOAD_H: `sen`=0, `sclk`=1 for `SCLK_HALF` cycles. The CPLD loads its latch on this rising edge. Then go to SHIFT_L.
- SHIFT_L: `sen`=1, `sclk`=0 for `SCLK_HALF` cycles.
  - On the last cycle, shift: `shreg <= {shreg[COUNTER_BITS-1:0], spi_miso}`.
  - If the bit counter is 0, go to DONE; otherwise go to SHIFT_H.
- SHIFT_H: `sen`=1, `sclk`=1 for `SCLK_HALF` cycles, decrement the bit counter, then go to SHIFT_L.
- Frame totals: `COUNTER_BITS+1` samples and `COUNTER_BITS` shift edges after the load edge.
- DONE (one cycle): `sen`=0, `sclk`=0, `rd_valid`=1, `rd_flag`=`shreg[COUNTER_BITS]`, `rd_count`=`shreg[COUNTER_BITS-1:0]`. Then go to IDLE.
- `start` while not in IDLE is ignored; it is not queued.
- `start` held high in IDLE starts back-to-back frames, with one IDLE cycle between them.
- Result outputs hold their value between strobes.
- Reset (including mid-frame): state IDLE, `spi_clk`=0, `spi_sen`=0, `spi_mosi`=0, `busy`=0, `rd_valid`=0, `rd_flag`=0, `rd_count`=0, `rd_delta`=0, `rd_delta_valid`=0, shift register 0, previous-capture register empty. An aborted frame produces no strobe.

## Timing
- `start` accepted at cycle 0 gives `rd_valid` at cycle `(2+2*COUNTER_BITS+1)*SCLK_HALF+1`. With defaults: 57*4+1 = 229.
- `spi_miso` is sampled `SCLK_HALF-1` cycles after the falling edge of `spi_clk`, i.e. one cycle before the rising edge.
- The CPLD output must settle within `SCLK_HALF-1` clk periods after that falling edge.
- All SPI outputs are driven from flops, glitch-free.
- `spi_sen` changes only while `spi_clk` is low.

## Configuration
- `CLOCK_COUNTER_READER_DELTA_EN` defined: keep `prev_count` and `prev_ok`.
  - On DONE with `rd_flag`=1 and `prev_ok`=1 and `rd_count`≠`prev_count`: `rd_delta` = (`rd_count` − `prev_count`) mod 2^`COUNTER_BITS`, `rd_delta_valid`=1, `prev_count` <= `rd_count`.
  - On DONE with `rd_flag`=1 and `prev_ok`=0: load `prev_count`, set `prev_ok`, `rd_delta_valid`=0.
  - On DONE with `rd_flag`=0, or `rd_count`=`prev_count`: `rd_delta_valid`=0, `prev_count` unchanged.
- Macro undefined: `rd_delta`=0 and `rd_delta_valid`=0 constantly; no delta registers are built.

## Structure
- Package `clock_counter_reader_pkg`: FSM state enum, frame-length localparam (`COUNTER_BITS+1`), half-period counter width localparam.
- Sub-module `ccr_half_timer`: loadable down-counter asserting `last` on the final cycle of each `SCLK_HALF` phase. The FSM uses it for every phase.

## Test plan
- Bench uses a behavioural CPLD model: latch on an `spi_clk` rising edge with `sen`=0, shift on a rising edge with `sen`=1, MSB on `miso`.
- Single read: model word {1, 27'h1234567}, pulse `start` → `rd_valid` at cycle 229, `rd_flag`=1, `rd_count`=27'h1234567. Check 28 sampled bits and exactly 28 `spi_clk` rising edges.
- Flag clear: model word {0, 27'h0} → `rd_flag`=0, `rd_delta_valid`=0.
- Delta with wrap (macro on): two reads returning 27'h7FFFF00 then 27'h00000FF → second strobe gives `rd_delta`=27'h1FF, `rd_delta_valid`=1. A third read of the same value → `rd_delta_valid`=0.
- Busy guard: extra `start` pulses at cycles 5 and 100 → one frame only, `busy` continuous, single `rd_valid`.
- Reset mid-frame: assert `nreset` at cycle 80 → `spi_clk`=0, `spi_sen`=0, `busy`=0 immediately, no `rd_valid`. A following `start` completes a normal frame.
- `SCLK_HALF`=2: single read → `rd_valid` at cycle 115, data correct.
